conv_maxpool: RTL

- Downstream stage of the convolution engine: consumes its row-major 16-bit result stream, one sample per valid cycle.
- Performs 2x2, stride-2 max-pooling and emits the pooled map row-major with coordinates.
- Holds one line buffer of horizontal pair maxima, so no full-frame storage.
- Frame dimensions are runtime inputs matching the convolution output size (inRow-kerRow+1 by inCol-kerCol+1).

---
 rtl/conv_maxpool_if.sv | 28 ++
 rtl/conv_maxpool.sv | 129 ++++++++++++
 2 files changed

// File: rtl/conv_maxpool_if.sv
// Stream interface of the max-pooling stage: frame configuration and sample
// input from the convolution engine, pooled samples and frame status out.
interface conv_maxpool_if #(
  parameter int DATA_W = 16
);
  logic [3:0]        cfg_rows;
  logic [3:0]        cfg_cols;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              frame_done;
  logic              busy;

  // Producer of samples and consumer of pooled results.
  modport master (
    output cfg_rows, cfg_cols, in_valid, in_data,
    input  out_valid, out_data, out_row, out_col, frame_done, busy
  );

  // The pooling block itself.
  modport slave (
    input  cfg_rows, cfg_cols, in_valid, in_data,
    output out_valid, out_data, out_row, out_col, frame_done, busy
  );
endinterface

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max-pooling of a row-major sample stream. Horizontal pair
// maxima of each even row are kept in a half-width line buffer and combined
// with the following odd row, so only one line of storage is needed.
module conv_maxpool #(
  parameter int DATA_W   = 16,
  parameter int MAX_COLS = 16
) (
  input logic          clk,
  input logic          rst_n,
  conv_maxpool_if.slave bus
);
  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int IDX_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [3:0]        rowsL;
  logic [3:0]        colsL;
  logic [3:0]        r;
  logic [3:0]        c;
  logic [DATA_W-1:0] pairReg;
  logic [DATA_W-1:0] lineBuf [LB_DEPTH];

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [2:0]        row_p1;
  logic [2:0]        col_p1;
  logic              done_p1;
  logic              busyReg;

  // Unsigned maximum; ties return the common value.
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // Stage p0: position of the incoming sample and its pooled candidates
  logic [3:0]        rowsEff;
  logic [3:0]        colsEff;
  logic [3:0]        rEff;
  logic [3:0]        cEff;
  logic              isLast;
  logic              rowEnd;
  logic [IDX_W-1:0]  lbIdx;
  logic [DATA_W-1:0] hmax_p0;
  logic [DATA_W-1:0] pool_p0;

  // In IDLE the sample is (0,0) of a new frame and the live config applies.
  always_comb begin
    rowsEff = rowsL;
    colsEff = colsL;
    rEff    = r;
    cEff    = c;
    if (state == IDLE) begin
      rowsEff = bus.cfg_rows;
      colsEff = bus.cfg_cols;
      rEff    = 4'd0;
      cEff    = 4'd0;
    end
    rowEnd  = (cEff == colsEff - 4'd1);
    isLast  = rowEnd && (rEff == rowsEff - 4'd1);
    lbIdx   = IDX_W'(cEff >> 1);
    hmax_p0 = umax(pairReg, bus.in_data);
    pool_p0 = umax(lineBuf[lbIdx], hmax_p0);
  end

  // Stage p1: frame control, pair/line-buffer update and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rowsL   <= '0;
      colsL   <= '0;
      r       <= '0;
      c       <= '0;
      pairReg <= '0;
      for (int i = 0; i < LB_DEPTH; i++) lineBuf[i] <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
      done_p1 <= 1'b0;
      busyReg <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (bus.in_valid) begin
        if (state == IDLE) begin
          rowsL <= bus.cfg_rows;
          colsL <= bus.cfg_cols;
        end
        if (isLast) begin
          state   <= IDLE;
          r       <= '0;
          c       <= '0;
          done_p1 <= 1'b1;
          busyReg <= 1'b0;
        end else begin
          state   <= RUN;
          busyReg <= 1'b1;
          if (rowEnd) begin
            c <= '0;
            r <= rEff + 4'd1;
          end else begin
            c <= cEff + 4'd1;
            r <= rEff;
          end
        end
        if (!cEff[0]) begin
          pairReg <= bus.in_data;
        end else if (!rEff[0]) begin
          lineBuf[lbIdx] <= hmax_p0;
        end else begin
          vld_p1  <= 1'b1;
          data_p1 <= pool_p0;
          row_p1  <= rEff[3:1];
          col_p1  <= cEff[3:1];
        end
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_data   = data_p1;
  assign bus.out_row    = row_p1;
  assign bus.out_col    = col_p1;
  assign bus.frame_done = done_p1;
  assign bus.busy       = busyReg;
endmodule
